// File: rtl/aw_router_if.sv
// AXI-Lite write-address/write-data bundle between one master and the slave ports of the
// interconnect, plus the registered slave index tapped by the B-channel router.
interface aw_router_if #(
    parameter int unsigned num_slaves = 5,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
) ();
    logic [ADDR_W-1:0]     m_awaddr;
    logic                  m_awvalid;
    logic                  m_awready;
    logic [DATA_W-1:0]     m_wdata;
    logic [DATA_W/8-1:0]   m_wstrb;
    logic                  m_wvalid;
    logic                  m_wready;
    logic                  m_bvalid;
    logic                  m_bready;
    logic [ADDR_W-1:0]     s_awaddr;
    logic [num_slaves-1:0] s_awvalid;
    logic [num_slaves-1:0] s_awready;
    logic [DATA_W-1:0]     s_wdata;
    logic [DATA_W/8-1:0]   s_wstrb;
    logic [num_slaves-1:0] s_wvalid;
    logic [num_slaves-1:0] s_wready;
    logic [2:0]            aw_sel_q;

    // Router side: slave of the master bus, master of the slave ports.
    modport slave (
        input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bvalid, m_bready,
        input  s_awready, s_wready,
        output m_awready, m_wready, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, aw_sel_q
    );

    // Environment side: the upstream master and the downstream slaves.
    modport master (
        output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bvalid, m_bready,
        output s_awready, s_wready,
        input  m_awready, m_wready, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, aw_sel_q
    );
endinterface

// File: rtl/aw_router.sv
// AXI-Lite write front end: accepts one master write, decodes the slave index from the address
// and steers AW then W to that slave, holding the index until the B beat completes.
module aw_router #(
    parameter int unsigned num_slaves    = 5,
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned SEL_LSB       = 12,
    parameter int unsigned DEFAULT_SLAVE = 4
) (
    input logic        aclk,
    input logic        aresetn,
    aw_router_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAw, StW, StB} state_e;

    state_e                state_q;
    logic [2:0]            sel_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [2:0]            idx;
    logic [num_slaves-1:0] sel_oh;
    logic                  sel_awready;
    logic                  sel_wready;

    assign idx = bus.m_awaddr[SEL_LSB+2:SEL_LSB];

    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < int'(num_slaves); i++) begin
            sel_oh[i] = (sel_q == 3'(i));
        end
    end

    // Readies from non-selected slaves are masked off.
    assign sel_awready = |(bus.s_awready & sel_oh);
    assign sel_wready  = |(bus.s_wready & sel_oh);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= StIdle;
            sel_q   <= 3'd0;
            addr_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.m_awvalid) begin
                        addr_q  <= bus.m_awaddr;
                        sel_q   <= (32'(idx) < num_slaves) ? idx : 3'(DEFAULT_SLAVE);
                        state_q <= StAw;
                    end
                end
                StAw: begin
                    if (sel_awready) state_q <= StW;
                end
                StW: begin
                    if (bus.m_wvalid && sel_wready) state_q <= StB;
                end
                StB: begin
                    if (bus.m_bvalid && bus.m_bready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Reset gates every handshake output immediately, before the first reset edge lands.
    assign bus.m_awready = aresetn && (state_q == StIdle);
    assign bus.s_awvalid = (aresetn && (state_q == StAw)) ? sel_oh : '0;
    assign bus.s_wvalid  = (aresetn && (state_q == StW) && bus.m_wvalid) ? sel_oh : '0;
    assign bus.m_wready  = aresetn && (state_q == StW) && sel_wready;
    assign bus.s_awaddr  = addr_q;
    assign bus.s_wdata   = bus.m_wdata;
    assign bus.s_wstrb   = bus.m_wstrb;
    assign bus.aw_sel_q  = sel_q;
endmodule

// File: tb/tb_aw_router.sv
// Randomised bench for aw_router: a transaction-level model predicts every output each cycle,
// and a few directed sequences pin hand-computed values.
module tb_aw_router;
    localparam int unsigned NS = 5;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SL = 12;
    localparam int unsigned DS = 4;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    aw_router_if #(.num_slaves(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

    aw_router #(
        .num_slaves   (NS),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .SEL_LSB      (SL),
        .DEFAULT_SLAVE(DS)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: one write in flight, described by which beats of it have completed.
    bit          busy     = 1'b0;
    bit          aw_done  = 1'b0;
    bit          w_done   = 1'b0;
    bit          seen_rst = 1'b0;
    logic [2:0]  m_sel    = 3'd0;
    logic [AW-1:0] m_addr = '0;

    bit          lit_en  = 1'b0;
    string       lit_name = "";
    logic        lit_awr;
    logic [NS-1:0] lit_awv;
    logic [NS-1:0] lit_wv;
    logic [2:0]  lit_sel;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [2:0] decode(input logic [AW-1:0] a);
        int unsigned f;
        f = (a >> SL) & 32'd7;
        return (f < NS) ? 3'(f) : 3'(DS);
    endfunction

    // Single compare process: outputs are stable here, inputs change only just after posedge.
    always @(negedge aclk) begin
        logic [NS-1:0] oh;
        bit aw_ph, w_ph, b_ph;
        oh = '0;
        oh[m_sel] = 1'b1;
        aw_ph = busy && !aw_done;
        w_ph  = busy && aw_done && !w_done;
        b_ph  = busy && w_done;
        if (seen_rst) begin
            check("m_awready", 64'(bus.m_awready), 64'(aresetn && !busy));
            check("s_awvalid", 64'(bus.s_awvalid), 64'((aresetn && aw_ph) ? oh : '0));
            check("s_wvalid", 64'(bus.s_wvalid),
                  64'((aresetn && w_ph && bus.m_wvalid) ? oh : '0));
            check("m_wready", 64'(bus.m_wready), 64'(aresetn && w_ph && bus.s_wready[m_sel]));
            check("s_awaddr", 64'(bus.s_awaddr), 64'(m_addr));
            check("aw_sel_q", 64'(bus.aw_sel_q), 64'(m_sel));
            check("s_wdata", 64'(bus.s_wdata), 64'(bus.m_wdata));
            check("s_wstrb", 64'(bus.s_wstrb), 64'(bus.m_wstrb));
        end
        if (lit_en) begin
            check({lit_name, ".m_awready"}, 64'(bus.m_awready), 64'(lit_awr));
            check({lit_name, ".s_awvalid"}, 64'(bus.s_awvalid), 64'(lit_awv));
            check({lit_name, ".s_wvalid"}, 64'(bus.s_wvalid), 64'(lit_wv));
            check({lit_name, ".aw_sel_q"}, 64'(bus.aw_sel_q), 64'(lit_sel));
        end
        // Advance the model to what the coming posedge must produce.
        if (!aresetn) begin
            seen_rst = 1'b1;
            busy = 1'b0; aw_done = 1'b0; w_done = 1'b0;
            m_sel = 3'd0; m_addr = '0;
        end else if (!busy) begin
            if (bus.m_awvalid) begin
                busy = 1'b1;
                m_addr = bus.m_awaddr;
                m_sel = decode(bus.m_awaddr);
            end
        end else if (aw_ph) begin
            if (bus.s_awready[m_sel]) aw_done = 1'b1;
        end else if (w_ph) begin
            if (bus.m_wvalid && bus.s_wready[m_sel]) w_done = 1'b1;
        end else if (b_ph) begin
            if (bus.m_bvalid && bus.m_bready) begin
                busy = 1'b0; aw_done = 1'b0; w_done = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic lit(input string n, input logic awr, input logic [NS-1:0] awv,
                       input logic [NS-1:0] wv, input logic [2:0] sel);
        lit_en = 1'b1; lit_name = n; lit_awr = awr; lit_awv = awv; lit_wv = wv; lit_sel = sel;
    endtask

    initial begin
        aresetn = 1'b0;
        bus.m_awaddr = '0; bus.m_awvalid = 1'b0; bus.m_wdata = '0; bus.m_wstrb = '0;
        bus.m_wvalid = 1'b0; bus.m_bvalid = 1'b0; bus.m_bready = 1'b0;
        bus.s_awready = '0; bus.s_wready = '0;
        repeat (2) step();

        // Decode idx 1 with zero-wait slaves; W offered early must wait for the AW phase.
        aresetn = 1'b1; bus.s_awready = '1; bus.s_wready = '1;
        bus.m_awaddr = 32'h0000_1000; bus.m_awvalid = 1'b1; bus.m_wvalid = 1'b1;
        bus.m_wdata = 32'hDEAD_BEEF; bus.m_wstrb = 4'hF;
        lit("t1_idle", 1'b1, 5'b00000, 5'b00000, 3'd0);
        step(); bus.m_awvalid = 1'b0;
        lit("t1_aw", 1'b0, 5'b00010, 5'b00000, 3'd1);
        step(); bus.m_bvalid = 1'b1; bus.m_bready = 1'b1;
        lit("t1_w", 1'b0, 5'b00000, 5'b00010, 3'd1);
        step(); bus.m_wvalid = 1'b0;
        lit("t1_b", 1'b0, 5'b00000, 5'b00000, 3'd1);
        step(); bus.m_bvalid = 1'b0; bus.m_bready = 1'b0;
        lit("t1_done", 1'b1, 5'b00000, 5'b00000, 3'd1);

        // Out-of-range index falls back to the error slave.
        bus.m_awaddr = 32'h0000_7000; bus.m_awvalid = 1'b1;
        step(); bus.m_awvalid = 1'b0;
        lit("t2_aw", 1'b0, 5'b10000, 5'b00000, 3'd4);
        step(); bus.m_wvalid = 1'b1;
        lit("t2_w", 1'b0, 5'b00000, 5'b10000, 3'd4);
        // A second AW during B waits for the B handshake.
        step(); bus.m_wvalid = 1'b0; bus.m_bvalid = 1'b1; bus.m_bready = 1'b0;
        bus.m_awaddr = 32'h0000_2000; bus.m_awvalid = 1'b1;
        lit("t5_b_stall", 1'b0, 5'b00000, 5'b00000, 3'd4);
        step(); bus.m_bready = 1'b1;
        lit("t5_b_hs", 1'b0, 5'b00000, 5'b00000, 3'd4);
        step(); bus.m_bvalid = 1'b0; bus.m_bready = 1'b0;
        lit("t5_idle", 1'b1, 5'b00000, 5'b00000, 3'd4);

        // Selected slave holds AW ready low for 5 cycles.
        step(); bus.m_awvalid = 1'b0; bus.s_awready = 5'b11011;
        for (int i = 0; i < 5; i++) begin
            lit("t3_aw_hold", 1'b0, 5'b00100, 5'b00000, 3'd2);
            step();
        end
        bus.s_awready = '1;
        lit("t3_aw_go", 1'b0, 5'b00100, 5'b00000, 3'd2);
        step();
        lit("t3_w", 1'b0, 5'b00000, 5'b00000, 3'd2);

        // Reset for one edge while in W.
        step(); aresetn = 1'b0; bus.m_wvalid = 1'b1;
        lit("t6_rst_low", 1'b0, 5'b00000, 5'b00000, 3'd2);
        step(); aresetn = 1'b1; bus.m_wvalid = 1'b0;
        lit("t6_release", 1'b1, 5'b00000, 5'b00000, 3'd0);
        step(); lit_en = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            aresetn       = ($urandom_range(0, 99) != 0);
            bus.m_awaddr  = $urandom;
            bus.m_awvalid = ($urandom_range(0, 1) != 0);
            bus.m_wdata   = $urandom;
            bus.m_wstrb   = 4'($urandom);
            bus.m_wvalid  = ($urandom_range(0, 9) < 6);
            bus.m_bvalid  = ($urandom_range(0, 9) < 6);
            bus.m_bready  = ($urandom_range(0, 9) < 6);
            bus.s_awready = NS'($urandom);
            bus.s_wready  = NS'($urandom);
            step();
        end
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
